bist_scan_controller: RTL and testbench

BIST_SCAN_CONTROLLER -- requirements
Module: bist_scan_controller

---
 rtl/bist_scan_controller.sv | 161 ++++++++++++++++
 tb/tb_bist_scan_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_scan_controller.sv
// BIST scan controller: LFSR patterns shifted into the CUT chains, responses compacted in a MISR, golden compare.
// Latency: bistdone rises NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles after start; no flow control, bistmode low aborts a run.
// Optional feature macro BIST_SIG_OUT_EN adds the misr_sig output (live signature).
module bist_scan_controller #(
    parameter int                NUM_CHAINS   = 1,
    parameter int                CHAIN_LEN    = 16,
    parameter int                NUM_PATTERNS = 4,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
    parameter int                MISR_W       = 16,
    parameter logic [MISR_W-1:0] MISR_POLY    = 16'h1021,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_W'(1),
    parameter logic [MISR_W-1:0] MISR_SEED    = '0,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bistmode,
    input  logic [NUM_CHAINS-1:0] cut_sdo,
    output logic                  cut_scanmode,
    output logic [NUM_CHAINS-1:0] cut_sdi,
    output logic                  busy,
    output logic                  bistdone,
`ifdef BIST_SIG_OUT_EN
    output logic                  bistpass,
    output logic [MISR_W-1:0]     misr_sig
`else
    output logic                  bistpass
`endif
);

    localparam int SC_W = $clog2(CHAIN_LEN + 1);
    localparam int PC_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_PATTERNS - 1);
    // An all-zero seed would lock the LFSR up.
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    if (NUM_CHAINS > LFSR_W || NUM_CHAINS > MISR_W) begin : g_bad_cfg
        $error("bist_scan_controller: NUM_CHAINS must not exceed LFSR_W or MISR_W");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
    } state_t;

    state_t            state;
    logic              bm_q;
    logic [LFSR_W-1:0] lfsr;
    logic [MISR_W-1:0] misr;
    logic [SC_W-1:0]   shift_cnt;
    logic [PC_W-1:0]   pat_cnt;
    logic              running;
    logic [LFSR_W-1:0] lfsr_next;
    logic [MISR_W-1:0] misr_next;

    assign running   = (state != S_IDLE) && (state != S_DONE);
    assign lfsr_next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign misr_next = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(cut_sdo);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            bm_q         <= 1'b1;
            lfsr         <= SEED_EFF;
            misr         <= MISR_SEED;
            shift_cnt    <= '0;
            pat_cnt      <= '0;
            cut_scanmode <= 1'b0;
            cut_sdi      <= '0;
            busy         <= 1'b0;
            bistdone     <= 1'b0;
            bistpass     <= 1'b0;
        end else begin
            bm_q <= bistmode;
            if (running && !bistmode) begin
                state        <= S_IDLE;
                lfsr         <= SEED_EFF;
                misr         <= MISR_SEED;
                shift_cnt    <= '0;
                pat_cnt      <= '0;
                cut_scanmode <= 1'b0;
                cut_sdi      <= '0;
                busy         <= 1'b0;
                bistdone     <= 1'b0;
                bistpass     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bistmode && !bm_q) begin
                            state        <= S_SHIFT;
                            lfsr         <= SEED_EFF;
                            misr         <= MISR_SEED;
                            shift_cnt    <= '0;
                            pat_cnt      <= '0;
                            cut_scanmode <= 1'b1;
                            cut_sdi      <= SEED_EFF[NUM_CHAINS-1:0];
                            busy         <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        // Chain content during pattern 0 is power-up garbage, not a response.
                        if (pat_cnt != '0)
                            misr <= misr_next;
                        lfsr <= lfsr_next;
                        if (shift_cnt == SC_LAST) begin
                            shift_cnt    <= '0;
                            state        <= S_CAPTURE;
                            cut_scanmode <= 1'b0;
                            cut_sdi      <= '0;
                        end else begin
                            shift_cnt <= shift_cnt + SC_W'(1);
                            cut_sdi   <= lfsr_next[NUM_CHAINS-1:0];
                        end
                    end
                    S_CAPTURE: begin
                        pat_cnt      <= pat_cnt + PC_W'(1);
                        cut_scanmode <= 1'b1;
                        if (pat_cnt < PC_LAST) begin
                            state   <= S_SHIFT;
                            cut_sdi <= lfsr[NUM_CHAINS-1:0];
                        end else begin
                            state   <= S_UNLOAD;
                            cut_sdi <= '0;
                        end
                    end
                    S_UNLOAD: begin
                        misr <= misr_next;
                        if (shift_cnt == SC_LAST) begin
                            shift_cnt    <= '0;
                            state        <= S_COMPARE;
                            cut_scanmode <= 1'b0;
                        end else begin
                            shift_cnt <= shift_cnt + SC_W'(1);
                        end
                    end
                    S_COMPARE: begin
                        bistpass <= (misr == GOLDEN_SIG);
                        bistdone <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end
                    S_DONE: begin
                        if (!bistmode) begin
                            state    <= S_IDLE;
                            bistdone <= 1'b0;
                            bistpass <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef BIST_SIG_OUT_EN
    // The MISR only moves in SHIFT/UNLOAD, so it is naturally frozen from COMPARE on.
    assign misr_sig = misr;
`endif

endmodule

// File: tb/tb_bist_scan_controller.sv
// Bench for bist_scan_controller: default instance fed by a 16-cycle delay line, plus a 4-chain instance.
module tb_bist_scan_controller;

    // Golden signature for the default configuration with cut_sdo = cut_sdi delayed 16 cycles.
    function automatic logic [15:0] model_sig();
        logic [15:0] lf;
        logic [15:0] m;
        logic [84:0] sdi_h;
        logic        sdo;
        int          r;
        lf    = 16'h0001;
        m     = 16'h0000;
        sdi_h = '0;
        for (int c = 0; c < 84; c++) begin
            r   = c % 17;
            sdo = 1'b0;
            if (c >= 16) sdo = sdi_h[c-16];
            if (c < 68 && r < 16) begin
                sdi_h[c] = lf[0];
                lf = {lf[14:0], ^(lf & 16'hB400)};
                if (c >= 17) m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, sdo};
            end else if (c >= 68) begin
                m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, sdo};
            end
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = model_sig();

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        bm    = 1'b0;
    logic        bm4   = 1'b0;
    logic        stuck = 1'b0;
    logic        sel   = 1'b0;
    logic [15:0] pipe  = '0;
    logic [3:0]  sdo4  = '0;
    logic        sdo1;
    logic        sm1, sdi1, busy1, done1, pass1;
    logic        sm4, busy4, done4, pass4;
    logic [3:0]  sdi4;
    logic [15:0] ms1, ms4;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) pipe <= {pipe[14:0], sdi1};
    assign sdo1 = stuck ? 1'b0 : pipe[15];

`ifndef BIST_SIG_OUT_EN
    assign ms1 = '0;
    assign ms4 = '0;
`endif

    bist_scan_controller #(.GOLDEN_SIG(GOLD)) u_dut (
        .clk(clk), .rst(rst_n), .bistmode(bm), .cut_sdo(sdo1),
        .cut_scanmode(sm1), .cut_sdi(sdi1), .busy(busy1), .bistdone(done1),
`ifdef BIST_SIG_OUT_EN
        .bistpass(pass1), .misr_sig(ms1)
`else
        .bistpass(pass1)
`endif
    );

    bist_scan_controller #(.NUM_CHAINS(4), .CHAIN_LEN(8), .NUM_PATTERNS(2)) u_dut4 (
        .clk(clk), .rst(rst_n), .bistmode(bm4), .cut_sdo(sdo4),
        .cut_scanmode(sm4), .cut_sdi(sdi4), .busy(busy4), .bistdone(done4),
`ifdef BIST_SIG_OUT_EN
        .bistpass(pass4), .misr_sig(ms4)
`else
        .bistpass(pass4)
`endif
    );

    wire        sm_v   = sel ? sm4 : sm1;
    wire [3:0]  sdi_v  = sel ? sdi4 : {3'b0, sdi1};
    wire        busy_v = sel ? busy4 : busy1;
    wire        done_v = sel ? done4 : done1;
    wire        pass_v = sel ? pass4 : pass1;
    wire [15:0] sig_v  = sel ? ms4 : ms1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a run on the selected instance and follows it cycle by cycle until bistdone.
    task automatic run_check(input string tag, input int cl, input int np, input int exp_done,
                             input int exp_scan, input logic exp_pass, input logic [3:0] mask,
                             input logic [15:0] exp_sig);
        logic [15:0] mlf;
        int          k;
        int          sm_cnt;
        mlf    = 16'h0001;
        k      = 0;
        sm_cnt = 0;
        @(negedge clk);
        if (sel) bm4 = 1'b1;
        else     bm  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_start"}, busy_v, 1);
        while (!done_v && k < 400) begin
            if (sm_v) sm_cnt++;
            if (k < np * (cl + 1) && (k % (cl + 1)) < cl) begin
                chk({tag, "_sdi"}, sdi_v, mlf[3:0] & mask);
                mlf = {mlf[14:0], ^(mlf & 16'hB400)};
            end else if (k >= np * (cl + 1) && k < np * (cl + 1) + cl) begin
                chk({tag, "_sdi_unload"}, sdi_v, 0);
            end
`ifdef BIST_SIG_OUT_EN
            if (k == exp_done - 1) chk({tag, "_sig_compare"}, sig_v, exp_sig);
`endif
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_cycle"}, k, exp_done);
        chk({tag, "_scan_cycles"}, sm_cnt, exp_scan);
        chk({tag, "_busy_done"}, busy_v, 0);
        chk({tag, "_pass"}, pass_v, exp_pass);
`ifdef BIST_SIG_OUT_EN
        chk({tag, "_sig_done"}, sig_v, exp_sig);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scanmode", sm1, 0);
        chk("rst_sdi", sdi1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_sdi4", sdi4, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        run_check("pass", 16, 4, 85, 80, 1'b1, 4'h1, GOLD);
        repeat (3) @(negedge clk);
        chk("done_hold", done1, 1);
        chk("pass_hold", pass1, 1);
`ifdef BIST_SIG_OUT_EN
        chk("sig_hold", ms1, GOLD);
`endif

        // Reset while in DONE, then release with bistmode still high.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_done_done", done1, 0);
        chk("rst_in_done_pass", pass1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_start_after_rst", busy1, 0);
        chk("no_scan_after_rst", sm1, 0);
        bm = 1'b0;
        repeat (3) @(negedge clk);

        stuck = 1'b1;
        run_check("stuck", 16, 4, 85, 80, 1'b0, 4'h1, 16'h0000);
        bm = 1'b0;
        @(negedge clk);
        chk("done_clear", done1, 0);
        chk("pass_clear", pass1, 0);
        stuck = 1'b0;

        // Abort at cycle 30, then a fresh run must reproduce the golden signature.
        @(negedge clk);
        bm = 1'b1;
        repeat (31) @(negedge clk);
        chk("abort_pre_busy", busy1, 1);
        bm = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy1, 0);
        chk("abort_scanmode", sm1, 0);
        chk("abort_done", done1, 0);
        repeat (2) @(negedge clk);
        run_check("rerun", 16, 4, 85, 80, 1'b1, 4'h1, GOLD);
        bm = 1'b0;
        repeat (3) @(negedge clk);

        sel = 1'b1;
        run_check("four", 8, 2, 27, 24, 1'b1, 4'hF, 16'h0000);
        bm4 = 1'b0;
        @(negedge clk);
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a SHIFT.
        bm = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_shift_scanmode", sm1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_scanmode", sm1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_pass", pass1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bm = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
